// File: rtl/image_deserializer_pkg.sv
// Shared frame geometry and types for the MNIST front end: pixel width, frame size,
// fill-counter width and the packed image vector handed to the model.
package image_deserializer_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int PIXEL_W    = 8;
  localparam int PIX_CNT_W  = $clog2(NUM_PIXELS);

  typedef logic [NUM_PIXELS-1:0] image_t;
  typedef logic [PIXEL_W-1:0]    pixel_t;
  typedef logic [PIX_CNT_W-1:0]  pix_cnt_t;

  localparam pix_cnt_t LAST_PIX = pix_cnt_t'(NUM_PIXELS - 1);

  // A frame restarted at position 0 holds only its first pixel.
  function automatic image_t first_pixel_image(input logic bin);
    return {{(NUM_PIXELS-1){1'b0}}, bin};
  endfunction

endpackage

// File: rtl/image_deserializer_if.sv
// Pixel-in / frame-out handshake bundle between the pixel source, the deserializer
// and the downstream model. master drives pixels and frame ready; slave is the stage.
interface image_deserializer_if;
  import image_deserializer_pkg::*;

  logic   valid_i;
  pixel_t data_i;
  logic   sof_i;
  logic   ready_o;
  logic   valid_o;
  image_t data_o;
  logic   ready_i;
  logic   frame_err_o;

  modport master (
    output valid_i, data_i, sof_i, ready_i,
    input  ready_o, valid_o, data_o, frame_err_o
  );

  modport slave (
    input  valid_i, data_i, sof_i, ready_i,
    output ready_o, valid_o, data_o, frame_err_o
  );

endinterface

// File: rtl/image_deserializer_pixel_threshold.sv
// Binarizes one grayscale pixel: output is 1 when the pixel is at or above THRESHOLD.
module image_deserializer_pixel_threshold
  import image_deserializer_pkg::*;
#(
  parameter int THRESHOLD = 128
) (
  input  pixel_t pixel,
  output logic   bin
);

  localparam pixel_t THR = pixel_t'(THRESHOLD);

  assign bin = (pixel >= THR);

endmodule

// File: rtl/image_deserializer.sv
// Double-buffered pixel-to-frame packer: a fill buffer collects binarized pixels while
// the output register holds the previous frame until the model accepts it.
module image_deserializer
  import image_deserializer_pkg::*;
#(
  parameter int THRESHOLD = 128
) (
  input  logic         clk_i,
  input  logic         reset_i,
  image_deserializer_if.slave bus
);

  logic     pix_bin;
  logic     accept;
  logic     xfer;
  logic     consume;
  logic     last_pix;

  logic     fill_full_p0;
  pix_cnt_t cnt_p0;
  image_t   fill_p0;
  logic     err_p0;

  logic     vld_p1;
  image_t   out_p1;

  image_deserializer_pixel_threshold #(
    .THRESHOLD (THRESHOLD)
  ) u_thr (
    .pixel (bus.data_i),
    .bin   (pix_bin)
  );

  // ready_o depends only on registered state, so upstream never sees a combinational path.
  assign accept   = bus.valid_i && !fill_full_p0;
  assign xfer     = fill_full_p0 && (!vld_p1 || bus.ready_i);
  assign consume  = vld_p1 && bus.ready_i;
  assign last_pix = (cnt_p0 == LAST_PIX);

  // Stage p0: fill buffer, pixel counter, abort detection
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fill_full_p0 <= 1'b0;
      cnt_p0       <= '0;
      fill_p0      <= '0;
      err_p0       <= 1'b0;
    end else begin
      err_p0 <= 1'b0;
      if (xfer) begin
        fill_full_p0 <= 1'b0;
        cnt_p0       <= '0;
        fill_p0      <= '0;
      end else if (accept) begin
        if (bus.sof_i) begin
          fill_p0 <= first_pixel_image(pix_bin);
          cnt_p0  <= pix_cnt_t'(1);
          err_p0  <= (cnt_p0 != '0);
        end else begin
          fill_p0[cnt_p0] <= pix_bin;
          if (last_pix) begin
            fill_full_p0 <= 1'b1;
          end else begin
            cnt_p0 <= cnt_p0 + pix_cnt_t'(1);
          end
        end
      end
    end
  end

  // Stage p1: output frame register; a transfer in the consume cycle keeps valid high
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_p1 <= 1'b0;
      out_p1 <= '0;
    end else if (xfer) begin
      vld_p1 <= 1'b1;
      out_p1 <= fill_p0;
    end else if (consume) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.ready_o     = !fill_full_p0;
  assign bus.valid_o     = vld_p1;
  assign bus.data_o      = out_p1;
  assign bus.frame_err_o = err_p0;

endmodule

// File: tb/tb_image_deserializer.sv
// Directed bench for image_deserializer: threshold packing, latency, backpressure,
// early start-of-frame abort, asynchronous reset and back-to-back streaming.
module tb_image_deserializer;
  import image_deserializer_pkg::*;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  image_deserializer_if bus ();

  image_deserializer #(.THRESHOLD(128)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic pixel_t pix(input int pat, input int k);
    case (pat)
      0: return (k % 2 == 1) ? 8'hFF : 8'h00;
      1: case (k % 4)
           0: return 8'd127;
           1: return 8'd128;
           2: return 8'd255;
           default: return 8'd0;
         endcase
      2: return 8'((k * 37 + 11) % 256);
      default: return 8'((k * k + 3 * k) % 256);
    endcase
  endfunction

  function automatic image_t expect_img(input int pat);
    image_t e;
    if (pat == 0) return {392{2'b10}};
    if (pat == 1) return {196{4'b0110}};
    for (int k = 0; k < NUM_PIXELS; k++) e[k] = (pix(pat, k) >= 8'd128);
    return e;
  endfunction

  function automatic int f_pat(input int i);
    return (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 3);
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input image_t obs, input image_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one pixel and return #1 after the edge that accepts it.
  task automatic send_pix(input pixel_t d, input logic s);
    int n;
    n = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.sof_i   = s;
    while (!bus.ready_o && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ready_o stayed %b for %0d cycles", bus.ready_o, n);
    end
    tick();
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
  endtask

  task automatic send_range(input int pat, input int lo, input int hi, input logic sof_first);
    for (int k = lo; k <= hi; k++) send_pix(pix(pat, k), (k == lo) ? sof_first : 1'b0);
  endtask

  initial begin
    int   idx, low, outs, last_c;
    logic rdy;
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.sof_i   = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;

    // Reset state
    chk1("rst_ready", bus.ready_o, 1'b1);
    chk1("rst_valid", bus.valid_o, 1'b0);
    chk_img("rst_data", bus.data_o, '0);
    chk1("rst_err", bus.frame_err_o, 1'b0);

    // 1) Alternating 0x00/0xFF, latency of exactly two cycles
    send_range(0, 0, NUM_PIXELS-1, 1'b0);
    chk1("t1_valid_n1", bus.valid_o, 1'b0);
    chk1("t1_ready_full", bus.ready_o, 1'b0);
    tick();
    chk1("t1_valid_n2", bus.valid_o, 1'b1);
    chk_img("t1_data", bus.data_o, {392{2'b10}});
    chk1("t1_ready_back", bus.ready_o, 1'b1);
    tick();
    chk1("t1_consumed", bus.valid_o, 1'b0);
    chk_img("t1_data_hold", bus.data_o, {392{2'b10}});

    // 2) Threshold edge 127/128/255/0
    send_range(1, 0, NUM_PIXELS-1, 1'b1);
    tick();
    chk1("t2_valid", bus.valid_o, 1'b1);
    chk_img("t2_data", bus.data_o, {196{4'b0110}});
    tick();
    chk1("t2_consumed", bus.valid_o, 1'b0);

    // 3) Backpressure with two frames stored
    bus.ready_i = 1'b0;
    send_range(2, 0, NUM_PIXELS-1, 1'b1);
    tick();
    chk1("t3_a_valid", bus.valid_o, 1'b1);
    chk_img("t3_a_data", bus.data_o, expect_img(2));
    send_range(3, 0, NUM_PIXELS-1, 1'b1);
    chk1("t3_ready_low", bus.ready_o, 1'b0);
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hFF;
    bus.sof_i   = 1'b1;
    repeat (3) tick();
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    chk1("t3_ready_held", bus.ready_o, 1'b0);
    chk1("t3_a_still_valid", bus.valid_o, 1'b1);
    chk_img("t3_a_stable", bus.data_o, expect_img(2));
    chk1("t3_no_err", bus.frame_err_o, 1'b0);
    bus.ready_i = 1'b1;
    tick();
    chk1("t3_b_valid", bus.valid_o, 1'b1);
    chk_img("t3_b_data", bus.data_o, expect_img(3));
    chk1("t3_ready_free", bus.ready_o, 1'b1);
    tick();
    chk1("t3_b_consumed", bus.valid_o, 1'b0);

    // 4) Early start-of-frame at pixel 300 aborts the partial frame
    send_range(2, 0, 0, 1'b1);
    chk1("t4_sof_at_zero", bus.frame_err_o, 1'b0);
    send_range(2, 1, 299, 1'b0);
    chk1("t4_no_output", bus.valid_o, 1'b0);
    send_range(3, 0, 0, 1'b1);
    chk1("t4_err_pulse", bus.frame_err_o, 1'b1);
    send_range(3, 1, 1, 1'b0);
    chk1("t4_err_one_cycle", bus.frame_err_o, 1'b0);
    send_range(3, 2, NUM_PIXELS-1, 1'b0);
    chk1("t4_aborted_not_out", bus.valid_o, 1'b0);
    tick();
    chk1("t4_valid", bus.valid_o, 1'b1);
    chk_img("t4_data", bus.data_o, expect_img(3));
    tick();
    chk1("t4_consumed", bus.valid_o, 1'b0);

    // 5) Asynchronous reset mid-frame with a frame pending on the output
    bus.ready_i = 1'b0;
    send_range(0, 0, NUM_PIXELS-1, 1'b1);
    tick();
    chk1("t5_pending", bus.valid_o, 1'b1);
    send_range(1, 0, 499, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    chk1("t5_rst_valid", bus.valid_o, 1'b0);
    chk_img("t5_rst_data", bus.data_o, '0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    chk1("t5_ready_after", bus.ready_o, 1'b1);
    chk1("t5_no_err", bus.frame_err_o, 1'b0);
    bus.ready_i = 1'b1;
    send_range(2, 0, NUM_PIXELS-1, 1'b0);
    tick();
    chk1("t5_fresh_valid", bus.valid_o, 1'b1);
    chk_img("t5_fresh_data", bus.data_o, expect_img(2));
    tick();
    chk1("t5_consumed", bus.valid_o, 1'b0);

    // 6) Back-to-back frames, valid_i and ready_i held high
    idx = 0; low = 0; outs = 0; last_c = 0;
    bus.ready_i = 1'b1;
    bus.sof_i   = 1'b0;
    for (int c = 0; c < 3*(NUM_PIXELS+1) + 3; c++) begin
      rdy = bus.ready_o;
      if (!rdy) low++;
      if (bus.valid_o) begin
        chk_img("t6_data", bus.data_o, expect_img(f_pat(outs)));
        if (outs == 0) chk_int("t6_first_at", c, NUM_PIXELS + 1);
        else           chk_int("t6_period", c - last_c, NUM_PIXELS + 1);
        last_c = c;
        outs++;
      end
      bus.valid_i = (idx < 3*NUM_PIXELS);
      bus.data_i  = pix(f_pat(idx / NUM_PIXELS), idx % NUM_PIXELS);
      tick();
      if (rdy && idx < 3*NUM_PIXELS) idx++;
    end
    bus.valid_i = 1'b0;
    chk_int("t6_frames", outs, 3);
    chk_int("t6_ready_low", low, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
